// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// default word/opcode widths and the test-program preload image.
package mem_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

    localparam int PRELOAD_DEPTH = 4;
    localparam logic [7:0] PRELOAD_IMAGE [0:PRELOAD_DEPTH-1] = '{8'h1E, 8'h3F, 8'hA2, 8'hE0};

endpackage

// File: rtl/mem_responder_if.sv
// Handshake/control bundle between the sequencer (master) and the memory
// responder (slave); the tri-state sysbus stays a separate port.
interface mem_responder_if #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
);
    logic [WORD_W-OP_W-1:0] addrbus;
    logic                   req;
    logic                   R_NW;
    logic                   load_MDR;
    logic                   MDR_bus;
    logic                   ready;
    logic                   busy;

    modport master (
        output addrbus, req, R_NW, load_MDR, MDR_bus,
        input  ready, busy
    );

    modport slave (
        input  addrbus, req, R_NW, load_MDR, MDR_bus,
        output ready, busy
    );
endinterface

// File: rtl/mem_responder_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Reset contents depend on MEM_PRELOAD_EN (test program) or all-zero otherwise.
module mem_array
    import mem_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_WORD_W - DEF_OP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage with reset image and single write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef MEM_PRELOAD_EN
                mem[i] <= (i < PRELOAD_DEPTH) ? WORD_W'(PRELOAD_IMAGE[i[1:0]]) : '0;
`else
                mem[i] <= '0;
`endif
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: req/ready framed word access with WAIT_STATES wait cycles,
// MDR exchanging data over the tri-state sysbus. Option: MEM_PRELOAD_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int OP_W        = DEF_OP_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_responder_if.slave    bus,
    inout  wire  [WORD_W-1:0] sysbus
);
    localparam int         ADDR_W    = WORD_W - OP_W;
    localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

    mem_state_t        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rnw_q;
    logic [WORD_W-1:0] mdr;
    logic [WORD_W-1:0] rdata;
    logic              ready_q;
    logic              busy_q;
    logic              mem_we;

    assign mem_we = (state == ST_ACCESS) && !rnw_q;

    mem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (mdr),
        .rdata (rdata)
    );

    // Access sequencer with registered ready/busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            addr_q  <= '0;
            rnw_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.req) begin
                        addr_q <= bus.addrbus;
                        rnw_q  <= bus.R_NW;
                        busy_q <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state   <= ST_DONE;
                    ready_q <= 1'b1;
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= 2'd0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // MDR: an array read in ACCESS takes priority over a bus load on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdr <= '0;
        end else if ((state == ST_ACCESS) && rnw_q) begin
            mdr <= rdata;
        end else if (bus.load_MDR) begin
            mdr <= sysbus;
        end
    end

    assign sysbus    = bus.MDR_bus ? mdr : {WORD_W{1'bz}};
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_STATES 1, 0, 3),
// pulled-up sysbus nets so a released bus reads all ones.
module tb_mem_responder;
    import mem_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_responder_if #(.WORD_W(8), .OP_W(3)) if1 ();
    mem_responder_if #(.WORD_W(8), .OP_W(3)) if0 ();
    mem_responder_if #(.WORD_W(8), .OP_W(3)) if3 ();

    wire [7:0] sb1;
    wire [7:0] sb0;
    wire [7:0] sb3;
    pullup (sb1);
    pullup (sb0);
    pullup (sb3);

    logic       drv_en  = 1'b0;
    logic [7:0] drv_val = 8'h00;
    assign sb1 = drv_en ? drv_val : 8'bz;

    mem_responder #(.WORD_W(8), .OP_W(3), .WAIT_STATES(1)) dut1 (
        .clock(clock), .reset(reset), .bus(if1), .sysbus(sb1));
    mem_responder #(.WORD_W(8), .OP_W(3), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .bus(if0), .sysbus(sb0));
    mem_responder #(.WORD_W(8), .OP_W(3), .WAIT_STATES(3)) dut3 (
        .clock(clock), .reset(reset), .bus(if3), .sysbus(sb3));

`ifdef MEM_PRELOAD_EN
    localparam logic [7:0] EXP_M0 = 8'h1E;
    localparam logic [7:0] EXP_M1 = 8'h3F;
    localparam logic [7:0] EXP_M2 = 8'hA2;
    localparam logic [7:0] EXP_M3 = 8'hE0;
`else
    localparam logic [7:0] EXP_M0 = 8'h00;
    localparam logic [7:0] EXP_M1 = 8'h00;
    localparam logic [7:0] EXP_M2 = 8'h00;
    localparam logic [7:0] EXP_M3 = 8'h00;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic [4:0] a, input logic rnw);
        case (sel)
            0:       begin if0.req = r; if0.addrbus = a; if0.R_NW = rnw; end
            3:       begin if3.req = r; if3.addrbus = a; if3.R_NW = rnw; end
            default: begin if1.req = r; if1.addrbus = a; if1.R_NW = rnw; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if0.ready;
            3:       return if3.ready;
            default: return if1.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return if0.busy;
            3:       return if3.busy;
            default: return if1.busy;
        endcase
    endfunction

    task automatic read_mdr(input int sel, output logic [7:0] v);
        case (sel)
            0:       begin if0.MDR_bus = 1'b1; #1; v = sb0; if0.MDR_bus = 1'b0; end
            3:       begin if3.MDR_bus = 1'b1; #1; v = sb3; if3.MDR_bus = 1'b0; end
            default: begin if1.MDR_bus = 1'b1; #1; v = sb1; if1.MDR_bus = 1'b0; end
        endcase
        #1;
    endtask

    task automatic load_mdr(input logic [7:0] v);
        drv_en = 1'b1; drv_val = v; if1.load_MDR = 1'b1;
        @(posedge clock); #1;
        if1.load_MDR = 1'b0; drv_en = 1'b0;
    endtask

    // One access: req pulse, then count edges to ready; optional load collision
    // on the ACCESS edge and a spurious req while busy.
    task automatic run_access(input int sel, input logic rnw, input logic [4:0] addr,
                              input int exp_lat, input logic coll, input logic spur);
        int   lat = 0;
        logic rdy = 1'b0;
        drive(sel, 1'b1, addr, rnw);
        @(posedge clock); #1;
        drive(sel, 1'b0, ~addr, ~rnw);
        check("busy_after_req", get_busy(sel), 1);
        while (!rdy && lat < 10) begin
            if (coll && lat == exp_lat - 1) begin
                drv_en = 1'b1; drv_val = 8'hFF; if1.load_MDR = 1'b1;
            end
            if (spur && lat == 1) drive(sel, 1'b1, 5'd9, 1'b0);
            @(posedge clock); #1;
            if1.load_MDR = 1'b0; drv_en = 1'b0;
            drive(sel, 1'b0, ~addr, ~rnw);
            lat++;
            rdy = get_ready(sel);
            if (!rdy) check("busy_mid", get_busy(sel), 1);
        end
        check("latency", lat, exp_lat);
        check("busy_in_done", get_busy(sel), 1);
        if (sel == 1) check("bus_release_done", sb1, 8'hFF);
        @(posedge clock); #1;
        check("ready_one_cycle", get_ready(sel), 0);
        check("busy_after_done", get_busy(sel), 0);
    endtask

    initial begin
        logic [7:0] v;
        int first;
        int second;
        if1.req = 1'b0; if1.addrbus = 5'd0; if1.R_NW = 1'b1; if1.load_MDR = 1'b0; if1.MDR_bus = 1'b0;
        if0.req = 1'b0; if0.addrbus = 5'd0; if0.R_NW = 1'b1; if0.load_MDR = 1'b0; if0.MDR_bus = 1'b0;
        if3.req = 1'b0; if3.addrbus = 5'd0; if3.R_NW = 1'b1; if3.load_MDR = 1'b0; if3.MDR_bus = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", if1.ready, 0);
        check("rst_busy", if1.busy, 0);
        check("rst_bus_released", sb1, 8'hFF);
        read_mdr(1, v);
        check("rst_mdr", v, 8'h00);
        reset = 1'b0;
        @(posedge clock); #1;

        run_access(1, 1'b1, 5'd1, 2, 1'b0, 1'b0);
        read_mdr(1, v);
        check("preload_read_a1", v, EXP_M1);

        load_mdr(8'h5A);
        read_mdr(1, v);
        check("mdr_load", v, 8'h5A);
        run_access(1, 1'b0, 5'd17, 2, 1'b0, 1'b0);
        load_mdr(8'h00);
        run_access(1, 1'b1, 5'd17, 2, 1'b0, 1'b0);
        read_mdr(1, v);
        check("write_read_a17", v, 8'h5A);
        run_access(1, 1'b1, 5'd16, 2, 1'b0, 1'b0);
        read_mdr(1, v);
        check("neighbour_a16", v, 8'h00);

        run_access(1, 1'b1, 5'd0, 2, 1'b1, 1'b0);
        read_mdr(1, v);
        check("override_a0", v, EXP_M0);

        load_mdr(8'hAA);
        drive(1, 1'b1, 5'd2, 1'b0);
        @(posedge clock); #1;
        drive(1, 1'b0, 5'd0, 1'b1);
        check("wait_busy", if1.busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_ready", if1.ready, 0);
        check("midrst_busy", if1.busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("midrst_stays_idle", if1.busy, 0);
        run_access(1, 1'b1, 5'd2, 2, 1'b0, 1'b0);
        read_mdr(1, v);
        check("midrst_a2", v, EXP_M2);

        run_access(0, 1'b1, 5'd3, 1, 1'b0, 1'b0);
        read_mdr(0, v);
        check("ws0_read_a3", v, EXP_M3);
        run_access(3, 1'b1, 5'd2, 4, 1'b0, 1'b1);
        read_mdr(3, v);
        check("ws3_read_a2", v, EXP_M2);

        first = -1;
        second = -1;
        drive(1, 1'b1, 5'd1, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (if1.ready) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        drive(1, 1'b0, 5'd0, 1'b1);
        repeat (6) @(posedge clock);
        #1;
        check("b2b_first", first, 3);
        check("b2b_period", second - first, 4);
        check("idle_bus_released", sb1, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
